// File: rtl/lsu_ctrl_pkg.sv
// rtl/lsu_ctrl_pkg.sv - shared control types: access kinds, LSU FSM states, strobe constants
package lsu_ctrl_pkg;

    typedef enum logic [2:0] {
        LS_NONE    = 3'd0,
        LS_BYTE    = 3'd1,
        LS_BYTE_U  = 3'd2,
        LS_HALFW   = 3'd3,
        LS_HALFW_U = 3'd4,
        LS_WORD    = 3'd5
    } ls_flag_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

endpackage

// File: rtl/lsu_ctrl_lane.sv
// rtl/lsu_ctrl_lane.sv - byte-lane steering: store strobe/replication, load extract and extend
module lsu_lane
    import lsu_ctrl_pkg::*;
(
    input  ls_flag_t    flag,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  strobe,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // pick the addressed byte and halfword out of the returned bus word
    always_comb begin
        byte_sel = rdata[8*addr_lo +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // per-kind strobe, store replication and load extension
    always_comb begin
        strobe    = STRB_NONE;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (flag)
            LS_BYTE, LS_BYTE_U: begin
                strobe    = STRB_BYTE << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = (flag == LS_BYTE) ? {{24{byte_sel[7]}}, byte_sel}
                                              : {24'd0, byte_sel};
            end
            LS_HALFW, LS_HALFW_U: begin
                strobe    = STRB_HALF << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = (flag == LS_HALFW) ? {{16{half_sel[15]}}, half_sel}
                                               : {16'd0, half_sel};
            end
            LS_WORD: begin
                strobe = STRB_WORD;
            end
            default: begin
                strobe = STRB_NONE;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - single-outstanding load/store unit controller; LSU_ALIGN_CHECK_EN enables misalignment trapping
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ex_valid,
    input  ls_flag_t          ex_ls_flag,
    input  logic              ex_mem_write,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic [4:0]        ex_dst,
    output logic              stall,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [3:0]        dreq_strobe,
    output logic [31:0]       dreq_wdata,
    input  logic              dreq_ready,
    input  logic              dresp_valid,
    input  logic [31:0]       dresp_data,
    output logic              wb_valid,
    output logic [4:0]        wb_dst,
    output logic [31:0]       wb_rdata,
    output logic              misalign
);

    lsu_state_t        state_q, state_d;
    ls_flag_t          flag_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [4:0]        dst_q;
    logic              mis_q;
    logic              accept;
    logic              mis_d;
    logic [3:0]        lane_strobe;

    assign accept = (state_q == ST_IDLE) && ex_valid && (ex_ls_flag != LS_NONE);

`ifdef LSU_ALIGN_CHECK_EN
    // misaligned word/halfword accesses bypass the bus entirely
    assign mis_d = ((ex_ls_flag == LS_WORD) && (ex_addr[1:0] != 2'b00)) ||
                   (((ex_ls_flag == LS_HALFW) || (ex_ls_flag == LS_HALFW_U)) && ex_addr[0]);
`else
    assign mis_d = 1'b0;
`endif

    // the pipeline is released only in the single DONE cycle
    assign stall = ex_valid && (ex_ls_flag != LS_NONE) && (state_q != ST_DONE);

    // state register; reset abandons any access in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // capture the instruction on accept and the bus response in WAIT
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flag_q  <= LS_NONE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            dst_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            if (accept) begin
                flag_q  <= ex_ls_flag;
                write_q <= ex_mem_write;
                addr_q  <= ex_addr;
                wdata_q <= ex_wdata;
                dst_q   <= ex_dst;
                mis_q   <= mis_d;
            end
            if ((state_q == ST_WAIT) && dresp_valid) begin
                rdata_q <= dresp_data;
            end
        end
    end

    // next-state and state-decoded outputs
    always_comb begin
        state_d    = state_q;
        dreq_valid = 1'b0;
        wb_valid   = 1'b0;
        misalign   = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) state_d = mis_d ? ST_DONE : ST_REQ;
            ST_REQ: begin
                dreq_valid = 1'b1;
                if (dreq_ready) state_d = ST_WAIT;
            end
            ST_WAIT: if (dresp_valid) state_d = ST_DONE;
            ST_DONE: begin
                wb_valid = !write_q && !mis_q;
                misalign = mis_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    lsu_lane u_lane (
        .flag      (flag_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (rdata_q),
        .strobe    (lane_strobe),
        .wdata_rep (dreq_wdata),
        .rdata_ext (wb_rdata)
    );

    assign dreq_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign dreq_strobe = write_q ? lane_strobe : STRB_NONE;
    assign wb_dst      = dst_q;

endmodule
